// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver
//   Accepts one command at a time, drives it to a registered ALU, captures the
//   result and the one-cycle-late zero flag, and presents a response that is
//   held until downstream takes it.
//
//   Optional feature: define ALU_CMD_DRIVER_CHECK_EN to build an independent
//   result checker that drives rsp_err. Without it rsp_err is tied to 0.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_a, cmd_b, cmd_op command operands and opcode
//   alu_a, alu_b, alu_op operands/opcode held toward the ALU
//   alu_result, alu_zero ALU outputs (zero lags result by one cycle)
//   rsp_valid/rsp_ready  response handshake
//   rsp_result, rsp_zero captured ALU outputs
//   rsp_err              checker mismatch flag
//   rsp_count            completed responses, wraps at 16 bits
module alu_cmd_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [15:0]      rsp_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    RES  = 3'd2,
    ZF   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [15:0]      rsp_count_q, rsp_count_d;

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_count_d  = rsp_count_q;
    case (state_q)
      // Operands load only here, so they stay stable until the handshake.
      IDLE: begin
        if (cmd_valid) begin
          alu_a_d  = cmd_a;
          alu_b_d  = cmd_b;
          alu_op_d = cmd_op;
          state_d  = EXEC;
        end
      end
      // ALU registers its result during this cycle.
      EXEC: state_d = RES;
      // Result is valid now; zero flag arrives one cycle later.
      RES: begin
        rsp_result_d = alu_result;
        state_d      = ZF;
      end
      ZF: begin
        rsp_zero_d = alu_zero;
        state_d    = RESP;
      end
      // Returning to IDLE (not accepting) keeps the handshake cycle command-free.
      RESP: begin
        if (rsp_ready) begin
          rsp_count_d = rsp_count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b1;
      rsp_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_count_q  <= rsp_count_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_count  = rsp_count_q;

`ifdef ALU_CMD_DRIVER_CHECK_EN
  // Reference result; illegal opcodes are expected to yield zero.
  function automatic logic [WIDTH-1:0] expected_result(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       op
  );
    logic [WIDTH-1:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] exp_q, exp_d;
  logic             err_q, err_d;

  always_comb begin
    exp_d = exp_q;
    err_d = err_q;
    if (state_q == RES) begin
      exp_d = expected_result(alu_a_q, alu_b_q, alu_op_q);
    end
    // rsp_result_q was captured on the RES edge, so compare it here with the zero flag.
    if (state_q == ZF) begin
      err_d = (rsp_result_q != exp_q) || (alu_zero != (exp_q == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;

`ifdef ALU_CMD_DRIVER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [7:0]  alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_result;
  logic        rsp_zero;
  logic        rsp_err;
  logic [15:0] rsp_count;

  int          tests = 0;
  int          fails = 0;
  int          exp_count = 0;
  bit          force_en = 1'b0;
  logic [7:0]  force_val = 8'h00;

  alu_cmd_driver #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .rsp_count(rsp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU result, plain integer arithmetic modulo 256.
  function automatic logic [7:0] model_res(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0:    r = (ia + ib) % 256;
      3'd1:    r = (ia - ib + 256) % 256;
      3'd2:    r = ia & ib;
      3'd3:    r = ia | ib;
      3'd4:    r = ia ^ ib;
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  // Attached ALU: registered result, zero flag one cycle behind the result.
  always @(posedge clk) begin
    alu_result <= force_en ? force_val : model_res(alu_a, alu_b, alu_op);
    alu_zero   <= (alu_result == 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle. Issues one command, waits for the response,
  // holds rsp_ready low for bp cycles (optionally with another command pending),
  // then completes the handshake and returns at the following negedge.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input int bp, input bit pend,
                         input logic [7:0] pa, input logic [7:0] pb, input logic [2:0] pop);
    logic [7:0] model, er;
    logic       ez, ee;
    int         lat;
    model = model_res(a, b, op);
    er    = force_en ? force_val : model;
    ez    = (er == 8'h00);
    ee    = CHECK_EN && ((er != model) || (ez != (model == 8'h00)));
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("alu_a_load", 32'(alu_a), 32'(a));
    check("alu_b_load", 32'(alu_b), 32'(b));
    check("alu_op_load", 32'(alu_op), 32'(op));
    check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
    check("rsp_result", 32'(rsp_result), 32'(er));
    check("rsp_zero", 32'(rsp_zero), 32'(ez));
    check("rsp_err", 32'(rsp_err), 32'(ee));
    if (pend) begin
      cmd_a = pa; cmd_b = pb; cmd_op = pop; cmd_valid = 1'b1;
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_result", 32'(rsp_result), 32'(er));
      check("bp_zero", 32'(rsp_zero), 32'(ez));
      check("bp_err", 32'(rsp_err), 32'(ee));
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_alu_a", 32'(alu_a), 32'(a));
      check("bp_alu_op", 32'(alu_op), 32'(op));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count = (exp_count + 1) % 65536;
    check("hs_valid_low", 32'(rsp_valid), 32'd0);
    check("hs_count", 32'(rsp_count), 32'(exp_count));
    check("hs_cmd_ready", 32'(cmd_ready), 32'd1);
    check("hs_no_accept", 32'(alu_a), 32'(a));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_op = 3'd0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_zero", 32'(rsp_zero), 32'd1);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_count", 32'(rsp_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed operations
    run_cmd(8'h05, 8'h03, 3'd0, 0, 1'b0, 8'h00, 8'h00, 3'd0);
    run_cmd(8'h0A, 8'h0A, 3'd1, 1, 1'b0, 8'h00, 8'h00, 3'd0);
    run_cmd(8'hFF, 8'h01, 3'd0, 0, 1'b0, 8'h00, 8'h00, 3'd0);
    run_cmd(8'hFF, 8'h01, 3'd7, 0, 1'b0, 8'h00, 8'h00, 3'd0);
    run_cmd(8'hF0, 8'h3C, 3'd2, 0, 1'b0, 8'h00, 8'h00, 3'd0);
    run_cmd(8'hF0, 8'h0C, 3'd3, 0, 1'b0, 8'h00, 8'h00, 3'd0);
    run_cmd(8'hA5, 8'hA5, 3'd4, 0, 1'b0, 8'h00, 8'h00, 3'd0);
    run_cmd(8'h03, 8'h05, 3'd1, 0, 1'b0, 8'h00, 8'h00, 3'd0);

    // Backpressure with a second command pending; it is taken one cycle after the handshake
    run_cmd(8'h12, 8'h34, 3'd2, 5, 1'b1, 8'h21, 8'h13, 3'd1);
    run_cmd(8'h21, 8'h13, 3'd1, 0, 1'b0, 8'h00, 8'h00, 3'd0);

    // Wrong ALU result, then a correct one
    force_en = 1'b1; force_val = 8'h07;
    run_cmd(8'h01, 8'h01, 3'd0, 0, 1'b0, 8'h00, 8'h00, 3'd0);
    force_en = 1'b0;
    run_cmd(8'h01, 8'h01, 3'd0, 0, 1'b0, 8'h00, 8'h00, 3'd0);

    // Randomized commands
    for (int n = 0; n < 20; n++) begin
      logic [7:0] ra, rb;
      logic [2:0] rop;
      int         rbp;
      ra  = 8'($urandom_range(255));
      rb  = 8'($urandom_range(255));
      rop = 3'($urandom_range(7));
      rbp = int'($urandom_range(3));
      run_cmd(ra, rb, rop, rbp, 1'b0, 8'h00, 8'h00, 3'd0);
    end

    // Reset while a command is in flight
    cmd_a = 8'h55; cmd_b = 8'h66; cmd_op = 3'd0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_count", 32'(rsp_count), 32'd0);
    check("mid_rst_alu_a", 32'(alu_a), 32'd0);
    check("mid_rst_alu_b", 32'(alu_b), 32'd0);
    check("mid_rst_zero", 32'(rsp_zero), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Normal operation resumes with the count restarted
    run_cmd(8'h40, 8'h02, 3'd1, 2, 1'b0, 8'h00, 8'h00, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
